imem_loader: RTL and testbench

- Synthesizable boot loader that streams a program into the 16-bit halfword instruction memory of the RV32IC core while holding the core in reset.
- Splits each incoming 32-bit word into one halfword (compressed) or two halfwords (full-length, bits[1:0]==2'b11).
- Pads the remainder with NOPs and plants a terminating self-loop, then releases the core.
- Sits between the external program source and the IF stage's instruction memory write port.

---
 rtl/imem_loader_pkg.sv | 35 +++
 rtl/imem_loader_halfword_splitter.sv | 34 +++
 rtl/imem_loader.sv | 218 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional feature macro used by imem_loader: IMEM_LOADER_CLEAR_EN.
package imem_loader_pkg;

    // Core reset polarity: cpu_rst == RESET holds the core in reset.
    localparam logic RESET = 1'b1;

    // Canonical RV32I nop (addi x0, x0, 0).
    localparam logic [31:0] NOOP = 32'h0000_0013;

    // c.nop, used to pad an odd halfword so the following pad is word aligned.
    localparam logic [15:0] C_NOP_HALFWORD = 16'h0001;

    // beq x0, x0, 0 split into halfwords: the core parks here after the program.
    localparam logic [15:0] TRAP_LO = 16'h0063;
    localparam logic [15:0] TRAP_HI = 16'h0000;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CLEAR   = 4'd1,
        ST_LOAD_LO = 4'd2,
        ST_LOAD_HI = 4'd3,
        ST_ALIGN   = 4'd4,
        ST_PAD     = 4'd5,
        ST_TRAP    = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } imem_loader_state_t;

    // Halfword of the padding nop that belongs at an even or odd address.
    function automatic logic [15:0] pad_halfword(input logic odd_addr);
        return odd_addr ? NOOP[31:16] : NOOP[15:0];
    endfunction

endpackage

// File: rtl/imem_loader_halfword_splitter.sv
// Classifies an incoming instruction word as compressed or full-length and
// holds the upper halfword of a full-length word for the following cycle.
module imem_halfword_splitter #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int HALFWORD_WIDTH    = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [INSTRUCTION_WIDTH-1:0] data_i,
    input  logic                         latch_i,
    output logic                         is_full_o,
    output logic [HALFWORD_WIDTH-1:0]    lo_o,
    output logic [HALFWORD_WIDTH-1:0]    hi_q_o
);

    logic [HALFWORD_WIDTH-1:0] hi_q;
    logic [HALFWORD_WIDTH-1:0] hi_d;

    // RISC-V length encoding: low two bits 2'b11 means a 32-bit instruction.
    assign is_full_o = (data_i[1:0] == 2'b11);
    assign lo_o      = data_i[HALFWORD_WIDTH-1:0];
    assign hi_d      = latch_i ? data_i[2*HALFWORD_WIDTH-1:HALFWORD_WIDTH] : hi_q;
    assign hi_q_o    = hi_q;

    // Keep the upper halfword until the loader writes it one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_q <= '0;
        end else begin
            hi_q <= hi_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a program into the halfword instruction memory while
// holding the core in reset, pads with nops, plants a self-loop, then
// releases the core. Optional macro IMEM_LOADER_CLEAR_EN zeroes the whole
// memory before the program is accepted.
//
// Handshake: a source word is consumed on a rising edge where in_valid and
// in_ready are both 1; in_ready is registered and only ever 1 in LOAD_LO,
// and the source must hold in_data/in_last stable until that edge.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_ADDRESS_WIDTH = 6,
    parameter int INSTRUCTION_WIDTH  = 32,
    parameter int HALFWORD_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0]  in_data,
    input  logic                          in_last,
    output logic                          mem_we,
    output logic [IMEM_ADDRESS_WIDTH-1:0] mem_addr,
    output logic [HALFWORD_WIDTH-1:0]     mem_wdata,
    output logic                          cpu_rst,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output imem_loader_state_t            state_o
);

    localparam int DEPTH = 2 ** IMEM_ADDRESS_WIDTH;
    typedef logic [IMEM_ADDRESS_WIDTH-1:0] addr_t;

    // Program may occupy 0..LAST_USABLE; the two top halfwords hold the trap.
    localparam addr_t LAST_USABLE = addr_t'(DEPTH - 3);
    localparam addr_t TRAP_ADDR   = addr_t'(DEPTH - 2);
    localparam addr_t END_ADDR    = addr_t'(DEPTH - 1);

    imem_loader_state_t        state_q;
    addr_t                     ptr_q;
    logic                      last_q;
    logic                      in_ready_q;
    logic                      mem_we_q;
    addr_t                     mem_addr_q;
    logic [HALFWORD_WIDTH-1:0] mem_wdata_q;
    logic                      cpu_rst_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      error_q;

    logic                      accept;
    logic                      is_full;
    logic                      overflow;
    logic                      latch_hi;
    logic [HALFWORD_WIDTH-1:0] lo_half;
    logic [HALFWORD_WIDTH-1:0] hi_half_q;
    logic [HALFWORD_WIDTH-1:0] fill_data_d;
    imem_loader_state_t        fill_state_d;

    assign accept   = (state_q == ST_LOAD_LO) && in_ready_q && in_valid;
    // A full word needs ptr and ptr+1, a compressed word only ptr.
    assign overflow = is_full ? (ptr_q >= LAST_USABLE) : (ptr_q > LAST_USABLE);
    assign latch_hi = accept && is_full && !overflow;

    imem_halfword_splitter #(
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
        .HALFWORD_WIDTH    (HALFWORD_WIDTH)
    ) u_splitter (
        .clk_i     (clk),
        .rst_i     (rst),
        .data_i    (in_data),
        .latch_i   (latch_hi),
        .is_full_o (is_full),
        .lo_o      (lo_half),
        .hi_q_o    (hi_half_q)
    );

    // Tail fill: choose the halfword for ptr and the state after writing it.
    // An even ptr in ALIGN is written as pad directly so no cycle is wasted.
    always_comb begin
        fill_data_d = pad_halfword(ptr_q[0]);
        if (state_q == ST_ALIGN && ptr_q[0]) begin
            fill_data_d = C_NOP_HALFWORD;
        end
        if (ptr_q == TRAP_ADDR) begin
            fill_data_d = TRAP_LO;
        end else if (ptr_q == END_ADDR) begin
            fill_data_d = TRAP_HI;
        end

        if (ptr_q == END_ADDR) begin
            fill_state_d = ST_DONE;
        end else if (ptr_q >= LAST_USABLE) begin
            fill_state_d = ST_TRAP;
        end else begin
            fill_state_d = ST_PAD;
        end
    end

    // Loader FSM with every output registered; at most one write per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= RESET;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (state_q == ST_DONE && busy_q) begin
                        // First cycle after the final trap write: release core.
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        cpu_rst_q <= ~RESET;
                    end else if (start) begin
                        ptr_q     <= '0;
                        done_q    <= 1'b0;
                        error_q   <= 1'b0;
                        cpu_rst_q <= RESET;
                        busy_q    <= 1'b1;
`ifdef IMEM_LOADER_CLEAR_EN
                        state_q    <= ST_CLEAR;
                        in_ready_q <= 1'b0;
`else
                        state_q    <= ST_LOAD_LO;
                        in_ready_q <= 1'b1;
`endif
                    end
                end
`ifdef IMEM_LOADER_CLEAR_EN
                ST_CLEAR: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= ptr_q;
                    mem_wdata_q <= '0;
                    ptr_q       <= ptr_q + addr_t'(1);
                    if (ptr_q == END_ADDR) begin
                        // in_ready rises on the following cycle from LOAD_LO.
                        ptr_q   <= '0;
                        state_q <= ST_LOAD_LO;
                    end
                end
`endif
                ST_LOAD_LO: begin
                    if (!in_ready_q) begin
                        in_ready_q <= 1'b1;
                    end else if (in_valid) begin
                        if (overflow) begin
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= ST_ERR;
                        end else begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= ptr_q;
                            mem_wdata_q <= lo_half;
                            if (is_full) begin
                                in_ready_q <= 1'b0;
                                last_q     <= in_last;
                                state_q    <= ST_LOAD_HI;
                            end else begin
                                ptr_q <= ptr_q + addr_t'(1);
                                if (in_last) begin
                                    in_ready_q <= 1'b0;
                                    state_q    <= ST_ALIGN;
                                end
                            end
                        end
                    end
                end
                ST_LOAD_HI: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= ptr_q + addr_t'(1);
                    mem_wdata_q <= hi_half_q;
                    ptr_q       <= ptr_q + addr_t'(2);
                    if (last_q) begin
                        state_q <= ST_ALIGN;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= ST_LOAD_LO;
                    end
                end
                ST_ALIGN, ST_PAD, ST_TRAP: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= ptr_q;
                    mem_wdata_q <= fill_data_d;
                    ptr_q       <= ptr_q + addr_t'(1);
                    state_q     <= fill_state_d;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed program streams, expected memory
// writes queued at start and checked by an independent write monitor.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = 64;
`ifdef IMEM_LOADER_CLEAR_EN
  localparam int CLR_EXTRA = DEPTH;
`else
  localparam int CLR_EXTRA = 0;
`endif
  localparam int BASE_LAT = DEPTH + 1 + CLR_EXTRA;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic               in_last;
  logic               mem_we;
  logic [5:0]         mem_addr;
  logic [15:0]        mem_wdata;
  logic               cpu_rst;
  logic               busy;
  logic               done;
  logic               error;
  imem_loader_state_t state_dbg;

  imem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .state_o   (state_dbg)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cyc = 0;
  int          t0 = 0;
  logic        sb_en = 1'b1;
  logic [21:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every memory write must match the queue head
  always @(negedge clk) begin
    if (sb_en && !rst && mem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_extra_write: got addr %0d data %h expected no write", mem_addr, mem_wdata);
      end else begin
        check("sb_write", {10'd0, mem_addr, mem_wdata}, {10'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push(input int a, input logic [15:0] d);
    logic [5:0] a6;
    a6 = a[5:0];
    exp_q.push_back({a6, d});
  endtask

  // expected writes for the reference three-word program
  task automatic push_std();
    push(0, 16'h0093); push(1, 16'h0050); push(2, 16'h4505);
    push(3, 16'h0113); push(4, 16'h0010); push(5, 16'h0001);
    for (int a = 6; a <= 61; a++) push(a, (a % 2 == 0) ? 16'h0013 : 16'h0000);
    push(62, 16'h0063);
    push(63, 16'h0000);
  endtask

  // driver: start pulse, with the outputs right after the start edge checked
  task automatic pulse_start();
`ifdef IMEM_LOADER_CLEAR_EN
    for (int a = 0; a < DEPTH; a++) push(a, 16'h0000);
`endif
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("start_in_ready", {31'd0, in_ready}, (CLR_EXTRA == 0) ? 32'd1 : 32'd0);
  endtask

  // driver: present one word, return just after the accepting edge
  task automatic send(input logic [31:0] data, input logic last);
    int n;
    n = 0;
    in_data = data;
    in_last = last;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stall(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n > 400) begin
        check("done_timeout", 32'd1, 32'd0);
        break;
      end
    end
    check("done_latency", cyc - t0 - 1, exp_lat);
    check("done_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_error", {31'd0, error}, 32'd0);
    check("done_in_ready", {31'd0, in_ready}, 32'd0);
    check("done_all_writes", exp_q.size(), 32'd0);
  endtask

  task automatic run_std();
    push_std();
    pulse_start();
    send(32'h0050_0093, 1'b0);
    send(32'h0000_4505, 1'b0);
    send(32'h0010_0113, 1'b1);
    in_valid = 1'b0;
    wait_done(BASE_LAT);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: reference program, source always valid
    run_std();

    // 2: three-cycle source stall between words delays done by three
    push_std();
    pulse_start();
    send(32'h0050_0093, 1'b0);
    send(32'h0000_4505, 1'b0);
    stall(3);
    send(32'h0010_0113, 1'b1);
    in_valid = 1'b0;
    wait_done(BASE_LAT + 3);

    // 5: start pulsed while waiting in LOAD_LO changes nothing
    push_std();
    pulse_start();
    send(32'h0050_0093, 1'b0);
    send(32'h0000_4505, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_state", 32'(state_dbg), 32'(ST_LOAD_LO));
    repeat (2) @(posedge clk);
    #1;
    send(32'h0010_0113, 1'b1);
    in_valid = 1'b0;
    wait_done(BASE_LAT + 3);

    // 3: 62 compressed words fill the usable region, a full word overflows
    for (int i = 0; i < 62; i++) push(i, 16'(i * 4 + 1));
    pulse_start();
    for (int i = 0; i < 62; i++) send({16'hDEAD, 16'(i * 4 + 1)}, 1'b0);
    send(32'h0050_0093, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("ovf_error", {31'd0, error}, 32'd1);
    check("ovf_state", 32'(state_dbg), 32'(ST_ERR));
    check("ovf_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("ovf_in_ready", {31'd0, in_ready}, 32'd0);
    check("ovf_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("ovf_all_writes", exp_q.size(), 32'd0);
    check("ovf_error_sticky", {31'd0, error}, 32'd1);

    // 4: reset during PAD, then a full clean load
    sb_en = 1'b0;
    exp_q.delete();
    pulse_start();
    check("restart_error_clr", {31'd0, error}, 32'd0);
    send(32'h0050_0093, 1'b0);
    send(32'h0000_4505, 1'b0);
    send(32'h0010_0113, 1'b1);
    in_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (state_dbg == ST_PAD) break;
    end
    check("reach_pad", 32'(state_dbg), 32'(ST_PAD));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("abort_we_ready", {30'd0, mem_we, in_ready}, 32'd0);
    check("abort_addr_data", {10'd0, mem_addr, mem_wdata}, 32'd0);
    check("abort_busy_done_err", {29'd0, busy, done, error}, 32'd0);
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    sb_en = 1'b1;
    repeat (2) @(negedge clk);
    run_std();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
